// File: rtl/dsp_decode_pipe_if.sv
// Signal bundle around the decode stage: fetch handshake, regfile read ports,
// writeback retire port and the decoded bundle handed to execute.
interface dsp_decode_pipe_if #(
    parameter int DATA_W = 16,
    parameter int INST_W = 32,
    parameter int NREG   = 32,
    parameter int CNT_W  = 16
);
    localparam int REG_AW = $clog2(NREG);

    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] instr;
    logic              flush;
    logic [REG_AW-1:0] rf_addr1;
    logic [REG_AW-1:0] rf_addr2;
    logic [REG_AW-1:0] rf_addr3;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [DATA_W-1:0] rf_data3;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_alu_mode;
    logic [2:0]        out_mem_mode;
    logic [2:0]        out_flow_mode;
    logic              out_wb_en;
    logic [REG_AW-1:0] out_dest;
    logic [4:0]        out_shamt;
    logic [DATA_W-1:0] out_s1;
    logic [DATA_W-1:0] out_s2;
    logic [DATA_W-1:0] out_s3;
    logic [DATA_W-1:0] out_jaddr;
    logic              out_illegal;
    logic              err_illegal;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, instr, flush, rf_data1, rf_data2, rf_data3,
               wb_valid, wb_addr, out_ready,
        input  in_ready, rf_addr1, rf_addr2, rf_addr3, out_valid,
               out_alu_mode, out_mem_mode, out_flow_mode, out_wb_en, out_dest,
               out_shamt, out_s1, out_s2, out_s3, out_jaddr, out_illegal,
               err_illegal, stall_cnt
    );

    modport slave (
        input  in_valid, instr, flush, rf_data1, rf_data2, rf_data3,
               wb_valid, wb_addr, out_ready,
        output in_ready, rf_addr1, rf_addr2, rf_addr3, out_valid,
               out_alu_mode, out_mem_mode, out_flow_mode, out_wb_en, out_dest,
               out_shamt, out_s1, out_s2, out_s3, out_jaddr, out_illegal,
               err_illegal, stall_cnt
    );
endinterface

// File: rtl/dsp_decode_pipe.sv
// Registered decode stage: one instruction per cycle, regfile operand fetch,
// scoreboard-based RAW/WAW stall, illegal-opcode flagging.
module dsp_decode_pipe #(
    parameter int DATA_W      = 16,
    parameter int INST_W      = 32,
    parameter int NREG        = 32,
    parameter int MAC_ACC_REG = 31,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    dsp_decode_pipe_if.slave bus
);
    localparam int REG_AW = $clog2(NREG);
    localparam logic [REG_AW-1:0] ACC_ADDR = REG_AW'(MAC_ACC_REG);

    typedef enum logic [7:0] {
        ALU_NOP  = 8'd0,  ALU_ADD  = 8'd1,  ALU_IADD = 8'd2,  ALU_SUB  = 8'd3,
        ALU_ISUB = 8'd4,  ALU_MUL  = 8'd5,  ALU_IMUL = 8'd6,  ALU_SQR  = 8'd7,
        ALU_MAC  = 8'd8,  ALU_AND  = 8'd9,  ALU_OR   = 8'd10, ALU_XOR  = 8'd11,
        ALU_SHLA = 8'd12, ALU_SHRA = 8'd13, ALU_SHLL = 8'd14, ALU_SHRL = 8'd15,
        ALU_ROL  = 8'd16, ALU_ROR  = 8'd17
    } alu_mode_e;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0, MEM_LD = 3'd1, MEM_ST = 3'd2, MEM_LD_IMM = 3'd3
    } mem_mode_e;

    typedef enum logic [2:0] {
        FLOW_NONE = 3'd0, FLOW_JMP = 3'd1, FLOW_BEZ = 3'd2, FLOW_BNEZ = 3'd3, FLOW_BEQ = 3'd4
    } flow_mode_e;

    // Operand/destination layout class of an opcode
    typedef enum logic [3:0] {
        FMT_BAD, FMT_R, FMT_I, FMT_SQR, FMT_MAC, FMT_JMP, FMT_BR1, FMT_BR2,
        FMT_LD, FMT_ST, FMT_LDI
    } fmt_e;

    logic [5:0]        w_op;
    logic [REG_AW-1:0] w_r1, w_r2, w_r3;
    logic [DATA_W-1:0] w_lit;
    alu_mode_e         w_alu;
    mem_mode_e         w_mem;
    flow_mode_e        w_flow;
    fmt_e              w_fmt;
    logic              w_use1, w_use2, w_use3;
    logic [REG_AW-1:0] w_addr1, w_addr2, w_addr3;
    logic [REG_AW-1:0] w_dest;
    logic              w_wb_en;
    logic [4:0]        w_shamt;
    logic              w_s1_lit, w_s2_lit, w_jump;
    logic [DATA_W-1:0] w_s1, w_s2, w_s3, w_jaddr;
    logic [NREG-1:0]   w_wb_clr, w_drop_clr, w_sb_set, w_sb_view;
    logic              w_hazard, w_in_ready, w_accept, w_drop;

    logic              r_out_valid;
    alu_mode_e         r_alu;
    mem_mode_e         r_mem;
    flow_mode_e        r_flow;
    logic              r_wb_en;
    logic [REG_AW-1:0] r_dest;
    logic [4:0]        r_shamt;
    logic [DATA_W-1:0] r_s1, r_s2, r_s3, r_jaddr;
    logic              r_illegal;
    logic              r_err;
    logic [CNT_W-1:0]  r_stall;
    logic [NREG-1:0]   r_sb;

    assign w_op  = bus.instr[31:26];
    assign w_r1  = REG_AW'(bus.instr[25:21]);
    assign w_r2  = REG_AW'(bus.instr[20:16]);
    assign w_r3  = REG_AW'(bus.instr[15:11]);
    assign w_lit = DATA_W'($signed(bus.instr[15:0]));

    always_comb begin
        w_alu  = ALU_NOP;
        w_mem  = MEM_NONE;
        w_flow = FLOW_NONE;
        w_fmt  = FMT_BAD;
        case (w_op)
            6'h00: begin w_alu = ALU_ADD;  w_fmt = FMT_R; end
            6'h01: begin w_alu = ALU_ADD;  w_fmt = FMT_I; end
            6'h02: begin w_alu = ALU_IADD; w_fmt = FMT_R; end
            6'h03: begin w_alu = ALU_IADD; w_fmt = FMT_I; end
            6'h04: begin w_alu = ALU_SUB;  w_fmt = FMT_R; end
            6'h05: begin w_alu = ALU_SUB;  w_fmt = FMT_I; end
            6'h06: begin w_alu = ALU_ISUB; w_fmt = FMT_R; end
            6'h07: begin w_alu = ALU_ISUB; w_fmt = FMT_I; end
            6'h08: begin w_alu = ALU_MUL;  w_fmt = FMT_R; end
            6'h09: begin w_alu = ALU_MUL;  w_fmt = FMT_I; end
            6'h0A: begin w_alu = ALU_IMUL; w_fmt = FMT_R; end
            6'h0B: begin w_alu = ALU_IMUL; w_fmt = FMT_I; end
            6'h0C: begin w_alu = ALU_SQR;  w_fmt = FMT_SQR; end
            6'h0D: begin w_alu = ALU_MAC;  w_fmt = FMT_MAC; end
            6'h10: begin w_alu = ALU_AND;  w_fmt = FMT_R; end
            6'h11: begin w_alu = ALU_AND;  w_fmt = FMT_I; end
            6'h12: begin w_alu = ALU_OR;   w_fmt = FMT_R; end
            6'h13: begin w_alu = ALU_OR;   w_fmt = FMT_I; end
            6'h14: begin w_alu = ALU_XOR;  w_fmt = FMT_R; end
            6'h15: begin w_alu = ALU_XOR;  w_fmt = FMT_I; end
            6'h16: begin w_alu = ALU_SHLA; w_fmt = FMT_R; end
            6'h17: begin w_alu = ALU_SHRA; w_fmt = FMT_R; end
            6'h18: begin w_alu = ALU_SHLL; w_fmt = FMT_R; end
            6'h19: begin w_alu = ALU_SHRL; w_fmt = FMT_R; end
            6'h1A: begin w_alu = ALU_ROL;  w_fmt = FMT_R; end
            6'h1B: begin w_alu = ALU_ROR;  w_fmt = FMT_R; end
            6'h20: begin w_flow = FLOW_JMP;  w_fmt = FMT_JMP; end
            6'h21: begin w_flow = FLOW_BEZ;  w_fmt = FMT_BR1; end
            6'h22: begin w_flow = FLOW_BNEZ; w_fmt = FMT_BR1; end
            6'h23: begin w_flow = FLOW_BEQ;  w_fmt = FMT_BR2; end
            6'h32: begin w_mem = MEM_LD;     w_fmt = FMT_LD; end
            6'h33: begin w_mem = MEM_ST;     w_fmt = FMT_ST; end
            6'h34: begin w_mem = MEM_LD_IMM; w_fmt = FMT_LDI; end
            default: ;
        endcase
    end

    // Register reads and destination per format; unused read ports address 0
    always_comb begin
        w_use1   = 1'b0;
        w_use2   = 1'b0;
        w_use3   = 1'b0;
        w_addr1  = '0;
        w_addr2  = '0;
        w_addr3  = '0;
        w_dest   = '0;
        w_wb_en  = 1'b0;
        w_shamt  = '0;
        w_s1_lit = 1'b0;
        w_s2_lit = 1'b0;
        w_jump   = 1'b0;
        case (w_fmt)
            FMT_R: begin
                w_use1 = 1'b1; w_addr1 = w_r1; w_use2 = 1'b1; w_addr2 = w_r2;
                w_dest = w_r3; w_wb_en = 1'b1; w_shamt = bus.instr[10:6];
            end
            FMT_I: begin
                w_use1 = 1'b1; w_addr1 = w_r1; w_s2_lit = 1'b1;
                w_dest = w_r2; w_wb_en = 1'b1;
            end
            FMT_SQR: begin
                w_use1 = 1'b1; w_addr1 = w_r1; w_use2 = 1'b1; w_addr2 = w_r1;
                w_dest = w_r3; w_wb_en = 1'b1; w_shamt = bus.instr[10:6];
            end
            FMT_MAC: begin
                w_use1 = 1'b1; w_addr1 = w_r1; w_use2 = 1'b1; w_addr2 = w_r2;
                w_use3 = 1'b1; w_addr3 = ACC_ADDR;
                w_dest = w_r3; w_wb_en = 1'b1; w_shamt = bus.instr[10:6];
            end
            FMT_JMP: w_jump = 1'b1;
            FMT_BR1: begin
                w_use1 = 1'b1; w_addr1 = w_r1; w_jump = 1'b1;
            end
            FMT_BR2: begin
                w_use1 = 1'b1; w_addr1 = w_r1; w_use2 = 1'b1; w_addr2 = w_r2; w_jump = 1'b1;
            end
            FMT_LD: begin
                w_use1 = 1'b1; w_addr1 = w_r2; w_dest = w_r1; w_wb_en = 1'b1;
            end
            FMT_ST: begin
                w_use1 = 1'b1; w_addr1 = w_r2; w_use2 = 1'b1; w_addr2 = w_r1;
            end
            FMT_LDI: begin
                w_s1_lit = 1'b1; w_dest = w_r1; w_wb_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_s1    = w_s1_lit ? w_lit : (w_use1 ? bus.rf_data1 : '0);
    assign w_s2    = w_s2_lit ? w_lit : (w_use2 ? bus.rf_data2 : '0);
    assign w_s3    = w_use3 ? bus.rf_data3 : '0;
    assign w_jaddr = w_jump ? w_lit : '0;

    // Same-cycle writeback release is visible to the hazard check
    assign w_wb_clr  = bus.wb_valid ? (NREG'(1) << bus.wb_addr) : '0;
    assign w_sb_view = r_sb & ~w_wb_clr;
    assign w_hazard  = (w_use1 && w_sb_view[w_addr1]) || (w_use2 && w_sb_view[w_addr2]) ||
                       (w_use3 && w_sb_view[w_addr3]) || (w_wb_en && w_sb_view[w_dest]);

    assign w_in_ready = rst_n && !bus.flush && !w_hazard && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_drop     = bus.flush && r_out_valid && !bus.out_ready && r_wb_en;
    assign w_drop_clr = w_drop ? (NREG'(1) << r_dest) : '0;
    assign w_sb_set   = (w_accept && w_wb_en) ? (NREG'(1) << w_dest) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= (r_sb & ~w_wb_clr & ~w_drop_clr) | w_sb_set;
        end
    end

    // Output bundle holds while execute back-pressures; flush only drops the valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu       <= ALU_NOP;
            r_mem       <= MEM_NONE;
            r_flow      <= FLOW_NONE;
            r_wb_en     <= 1'b0;
            r_dest      <= '0;
            r_shamt     <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
            r_jaddr     <= '0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_alu       <= w_alu;
            r_mem       <= w_mem;
            r_flow      <= w_flow;
            r_wb_en     <= w_wb_en;
            r_dest      <= w_dest;
            r_shamt     <= w_shamt;
            r_s1        <= w_s1;
            r_s2        <= w_s2;
            r_s3        <= w_s3;
            r_jaddr     <= w_jaddr;
            r_illegal   <= (w_fmt == FMT_BAD);
        end else if (bus.flush || bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err   <= 1'b0;
            r_stall <= '0;
        end else begin
            if (w_accept && (w_fmt == FMT_BAD)) begin
                r_err <= 1'b1;
            end
            if (bus.in_valid && w_hazard && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.rf_addr1      = w_addr1;
    assign bus.rf_addr2      = w_addr2;
    assign bus.rf_addr3      = w_addr3;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_alu_mode  = r_alu;
    assign bus.out_mem_mode  = r_mem;
    assign bus.out_flow_mode = r_flow;
    assign bus.out_wb_en     = r_wb_en;
    assign bus.out_dest      = r_dest;
    assign bus.out_shamt     = r_shamt;
    assign bus.out_s1        = r_s1;
    assign bus.out_s2        = r_s2;
    assign bus.out_s3        = r_s3;
    assign bus.out_jaddr     = r_jaddr;
    assign bus.out_illegal   = r_illegal;
    assign bus.err_illegal   = r_err;
    assign bus.stall_cnt     = r_stall;
endmodule

// File: tb/tb_dsp_decode_pipe.sv
// Bench for dsp_decode_pipe (DATA_W=24): directed cases followed by random traffic
// checked against an opcode-table reference model with a bitmask scoreboard.
module tb_dsp_decode_pipe;
    logic clk;
    logic rst_n;

    dsp_decode_pipe_if #(.DATA_W(24), .INST_W(32), .NREG(32), .CNT_W(16)) bus ();

    dsp_decode_pipe #(
        .DATA_W(24), .INST_W(32), .NREG(32), .MAC_ACC_REG(31), .CNT_W(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] rf [32];
    assign bus.rf_data1 = rf[bus.rf_addr1];
    assign bus.rf_data2 = rf[bus.rf_addr2];
    assign bus.rf_data3 = rf[bus.rf_addr3];

    typedef struct packed {
        logic [7:0]  alu;
        logic [2:0]  mem;
        logic [2:0]  flow;
        logic        wb_en;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        logic [23:0] s1;
        logic [23:0] s2;
        logic [23:0] s3;
        logic [23:0] jaddr;
        logic        illegal;
        logic [31:0] srcMask;
    } bundle_t;

    int          assertCount;
    int          failCount;
    logic [31:0] expSb;
    bundle_t     expOut;
    logic        expValid;
    logic        expErr;
    logic [15:0] expStall;
    int          execQ[$];
    logic        lastAccept;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Codes: ADD..IMUL = 1..6, SQR 7, MAC 8, AND/OR/XOR 9..11, SHLA..ROR 12..17
    function automatic bundle_t refDecode(input logic [31:0] ins);
        bundle_t     b;
        int          op, r1, r2, r3;
        logic [23:0] lit;
        b   = '0;
        op  = int'(ins[31:26]);
        r1  = int'(ins[25:21]);
        r2  = int'(ins[20:16]);
        r3  = int'(ins[15:11]);
        lit = {{8{ins[15]}}, ins[15:0]};
        if (op <= 11 || (op >= 16 && op <= 21) || (op >= 22 && op <= 27)) begin
            if (op <= 11)      b.alu = 8'(1 + op / 2);
            else if (op <= 21) b.alu = 8'(9 + (op - 16) / 2);
            else               b.alu = 8'(12 + op - 22);
            b.wb_en = 1'b1;
            if (op <= 21 && (op % 2) == 1) begin
                b.s1 = rf[r1]; b.s2 = lit; b.dest = 5'(r2);
                b.srcMask = 32'd1 << r1;
            end else begin
                b.s1 = rf[r1]; b.s2 = rf[r2]; b.dest = 5'(r3); b.shamt = ins[10:6];
                b.srcMask = (32'd1 << r1) | (32'd1 << r2);
            end
        end else if (op == 12) begin
            b.alu = 8'd7; b.s1 = rf[r1]; b.s2 = rf[r1]; b.dest = 5'(r3);
            b.wb_en = 1'b1; b.shamt = ins[10:6]; b.srcMask = 32'd1 << r1;
        end else if (op == 13) begin
            b.alu = 8'd8; b.s1 = rf[r1]; b.s2 = rf[r2]; b.s3 = rf[31]; b.dest = 5'(r3);
            b.wb_en = 1'b1; b.shamt = ins[10:6];
            b.srcMask = (32'd1 << r1) | (32'd1 << r2) | (32'd1 << 31);
        end else if (op >= 32 && op <= 35) begin
            b.flow  = 3'(op - 31);
            b.jaddr = lit;
            if (op >= 33) begin b.s1 = rf[r1]; b.srcMask = 32'd1 << r1; end
            if (op == 35) begin b.s2 = rf[r2]; b.srcMask |= 32'd1 << r2; end
        end else if (op == 50) begin
            b.mem = 3'd1; b.s1 = rf[r2]; b.dest = 5'(r1); b.wb_en = 1'b1; b.srcMask = 32'd1 << r2;
        end else if (op == 51) begin
            b.mem = 3'd2; b.s1 = rf[r2]; b.s2 = rf[r1];
            b.srcMask = (32'd1 << r1) | (32'd1 << r2);
        end else if (op == 52) begin
            b.mem = 3'd3; b.s1 = lit; b.dest = 5'(r1); b.wb_en = 1'b1;
        end else begin
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    task automatic checkBundle();
        checkOutput("alu_mode",  64'(bus.out_alu_mode),  64'(expOut.alu));
        checkOutput("mem_mode",  64'(bus.out_mem_mode),  64'(expOut.mem));
        checkOutput("flow_mode", 64'(bus.out_flow_mode), 64'(expOut.flow));
        checkOutput("wb_en",     64'(bus.out_wb_en),     64'(expOut.wb_en));
        checkOutput("dest",      64'(bus.out_dest),      64'(expOut.dest));
        checkOutput("shamt",     64'(bus.out_shamt),     64'(expOut.shamt));
        checkOutput("s1",        64'(bus.out_s1),        64'(expOut.s1));
        checkOutput("s2",        64'(bus.out_s2),        64'(expOut.s2));
        checkOutput("s3",        64'(bus.out_s3),        64'(expOut.s3));
        checkOutput("jaddr",     64'(bus.out_jaddr),     64'(expOut.jaddr));
        checkOutput("illegal",   64'(bus.out_illegal),   64'(expOut.illegal));
    endtask

    // One clock: drive, check handshake mid-cycle, advance the model, check registered state
    task automatic applyStimulus(input logic iv, input logic [31:0] ins, input logic fl,
                                 input logic ordy, input logic wv, input logic [4:0] wa);
        bundle_t     b;
        logic [31:0] need, view, nextSb;
        logic        hz, expReady;
        bus.in_valid  = iv;
        bus.instr     = ins;
        bus.flush     = fl;
        bus.out_ready = ordy;
        bus.wb_valid  = wv;
        bus.wb_addr   = wa;
        @(negedge clk);
        b        = refDecode(ins);
        need     = b.srcMask | (b.wb_en ? (32'd1 << b.dest) : 32'd0);
        view     = expSb & ~(wv ? (32'd1 << wa) : 32'd0);
        hz       = |(need & view);
        expReady = !fl && !hz && (!expValid || ordy);
        checkOutput("in_ready", 64'(bus.in_ready), 64'(expReady));
        lastAccept = iv && expReady;
        if (iv && hz && expStall != 16'hFFFF) expStall++;
        if (expValid && ordy && expOut.wb_en) execQ.push_back(int'(expOut.dest));
        nextSb = view;
        if (fl && expValid && !ordy && expOut.wb_en) nextSb[expOut.dest] = 1'b0;
        if (lastAccept && b.wb_en) nextSb[b.dest] = 1'b1;
        expSb = nextSb;
        if (lastAccept) begin
            expOut   = b;
            expValid = 1'b1;
            if (b.illegal) expErr = 1'b1;
        end else if (fl || ordy) begin
            expValid = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid",   64'(bus.out_valid),   64'(expValid));
        checkOutput("err_illegal", 64'(bus.err_illegal), 64'(expErr));
        checkOutput("stall_cnt",   64'(bus.stall_cnt),   64'(expStall));
        if (expValid) checkBundle();
    endtask

    task automatic doReset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(bus.out_valid),   64'(0));
        checkOutput("rst_in_ready",  64'(bus.in_ready),    64'(0));
        checkOutput("rst_err",       64'(bus.err_illegal), 64'(0));
        checkOutput("rst_stall",     64'(bus.stall_cnt),   64'(0));
        checkOutput("rst_s1",        64'(bus.out_s1),      64'(0));
        checkOutput("rst_dest",      64'(bus.out_dest),    64'(0));
        expSb    = '0;
        expOut   = '0;
        expValid = 1'b0;
        expErr   = 1'b0;
        expStall = '0;
        execQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] ins;
        logic [5:0]  op;
        bundle_t     probe;
        logic        wantBad;
        wantBad = ($urandom_range(0, 9) == 0);
        do begin
            op    = 6'($urandom);
            probe = refDecode({op, 26'd0});
        end while (probe.illegal != wantBad);
        ins        = $urandom;
        ins[31:26] = op;
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    localparam logic [31:0] ADD_1_2_3  = {6'h00, 5'd1, 5'd2, 5'd3, 11'd0};
    localparam logic [31:0] SUB_3_4_5  = {6'h04, 5'd3, 5'd4, 5'd5, 11'd0};
    localparam logic [31:0] ADDI_1_6   = {6'h01, 5'd1, 5'd6, 16'hFFFE};
    localparam logic [31:0] XOR_7_8_9  = {6'h14, 5'd7, 5'd8, 5'd9, 11'd0};
    localparam logic [31:0] AND_A_B_C  = {6'h10, 5'd10, 5'd11, 5'd12, 11'd0};
    localparam logic [31:0] BAD_OP     = {6'h3F, 26'h2AAAAAA};
    localparam logic [31:0] ADD_1_2_14 = {6'h00, 5'd1, 5'd2, 5'd14, 11'd0};
    localparam logic [31:0] MAC_1_2_5  = {6'h0D, 5'd1, 5'd2, 5'd5, 11'd0};

    initial begin
        logic [31:0] curInstr;
        logic        needNew;
        logic        iv, fl, ordy, wv;
        logic [4:0]  wa;
        int          idx;
        assertCount = 0;
        failCount   = 0;
        lastAccept  = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 24'($urandom);
        rf[1] = 24'd5;
        rf[2] = 24'd7;
        doReset();

        applyStimulus(1'b1, ADD_1_2_3, 1'b0, 1'b1, 1'b0, 5'd0);
        checkOutput("add_alu",  64'(bus.out_alu_mode), 64'(1));
        checkOutput("add_s1",   64'(bus.out_s1),       64'(5));
        checkOutput("add_s2",   64'(bus.out_s2),       64'(7));
        checkOutput("add_dest", 64'(bus.out_dest),     64'(3));
        checkOutput("add_wb",   64'(bus.out_wb_en),    64'(1));

        repeat (2) applyStimulus(1'b1, SUB_3_4_5, 1'b0, 1'b1, 1'b0, 5'd0);
        checkOutput("raw_stall_cnt", 64'(bus.stall_cnt), 64'(2));
        execQ.delete();
        applyStimulus(1'b1, SUB_3_4_5, 1'b0, 1'b1, 1'b1, 5'd3);
        checkOutput("release_dest", 64'(bus.out_dest), 64'(5));

        applyStimulus(1'b1, ADDI_1_6, 1'b0, 1'b1, 1'b0, 5'd0);
        checkOutput("addi_s2",    64'(bus.out_s2),    64'(24'hFFFFFE));
        checkOutput("addi_dest",  64'(bus.out_dest),  64'(6));
        checkOutput("addi_shamt", 64'(bus.out_shamt), 64'(0));

        applyStimulus(1'b1, XOR_7_8_9, 1'b0, 1'b1, 1'b0, 5'd0);
        repeat (4) begin
            applyStimulus(1'b1, AND_A_B_C, 1'b0, 1'b0, 1'b0, 5'd0);
            checkOutput("held_dest", 64'(bus.out_dest), 64'(9));
        end
        applyStimulus(1'b1, AND_A_B_C, 1'b0, 1'b1, 1'b0, 5'd0);
        checkOutput("after_hold_dest", 64'(bus.out_dest), 64'(12));

        applyStimulus(1'b1, BAD_OP, 1'b0, 1'b1, 1'b0, 5'd0);
        checkOutput("bad_illegal", 64'(bus.out_illegal), 64'(1));
        checkOutput("bad_wb",      64'(bus.out_wb_en),   64'(0));
        applyStimulus(1'b1, ADD_1_2_14, 1'b0, 1'b1, 1'b0, 5'd0);
        checkOutput("err_sticky", 64'(bus.err_illegal), 64'(1));

        doReset();
        applyStimulus(1'b1, MAC_1_2_5, 1'b0, 1'b1, 1'b0, 5'd0);
        checkOutput("mac_addr3", 64'(bus.rf_addr3), 64'(31));
        checkOutput("mac_s3",    64'(bus.out_s3),   64'(rf[31]));

        doReset();
        applyStimulus(1'b1, ADD_1_2_3, 1'b0, 1'b1, 1'b0, 5'd0);
        repeat (2) applyStimulus(1'b1, SUB_3_4_5, 1'b0, 1'b1, 1'b0, 5'd0);
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_valid", 64'(bus.out_valid),    64'(0));
        checkOutput("midrst_alu",   64'(bus.out_alu_mode), 64'(0));
        checkOutput("midrst_dest",  64'(bus.out_dest),     64'(0));
        checkOutput("midrst_stall", 64'(bus.stall_cnt),    64'(0));
        checkOutput("midrst_ready", 64'(bus.in_ready),     64'(0));
        doReset();
        applyStimulus(1'b1, SUB_3_4_5, 1'b0, 1'b1, 1'b0, 5'd0);

        doReset();
        needNew  = 1'b1;
        curInstr = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (needNew) curInstr = randInstr();
            if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = 24'($urandom);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            wv   = 1'b0;
            wa   = '0;
            if (execQ.size() > 0 && $urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, execQ.size() - 1);
                wa  = 5'(execQ[idx]);
                execQ.delete(idx);
                wv  = 1'b1;
            end
            applyStimulus(iv, curInstr, fl, ordy, wv, wa);
            needNew = lastAccept || !iv;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
